// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals, sync boundaries and the per-axis decode helper
// used by the request generator.
package vga_timing_pkg;

    localparam int unsigned IdxW      = 10;
    localparam int unsigned AddrW     = 20;
    localparam int unsigned FrameCntW = 8;

    localparam int unsigned HActiveDef = 640;
    localparam int unsigned HFpDef     = 16;
    localparam int unsigned HSyncDef   = 96;
    localparam int unsigned HBpDef     = 48;
    localparam int unsigned VActiveDef = 480;
    localparam int unsigned VFpDef     = 10;
    localparam int unsigned VSyncDef   = 2;
    localparam int unsigned VBpDef     = 33;

    localparam int unsigned HTotalDef = HActiveDef + HFpDef + HSyncDef + HBpDef;
    localparam int unsigned VTotalDef = VActiveDef + VFpDef + VSyncDef + VBpDef;

    localparam int unsigned HSyncStartDef = HActiveDef + HFpDef;
    localparam int unsigned HSyncEndDef   = HSyncStartDef + HSyncDef - 1;
    localparam int unsigned VSyncStartDef = VActiveDef + VFpDef;
    localparam int unsigned VSyncEndDef   = VSyncStartDef + VSyncDef - 1;

    typedef struct packed {
        logic active;
        logic sync_n;
    } axis_decode_t;

    function automatic int unsigned sync_start(int unsigned active, int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned sync_end(int unsigned active, int unsigned fp,
                                             int unsigned width);
        return active + fp + width - 1;
    endfunction

    function automatic axis_decode_t axis_decode(logic [IdxW-1:0] idx,
                                                 logic [IdxW-1:0] active,
                                                 logic [IdxW-1:0] sync_first,
                                                 logic [IdxW-1:0] sync_last);
        axis_decode_t d;
        d.active = (idx < active);
        d.sync_n = !((idx >= sync_first) && (idx <= sync_last));
        return d;
    endfunction

endpackage

// File: rtl/vga_request_gen_if.sv
// Request/timing bundle between the VGA request generator (master) and its consumer (slave).
interface vga_request_gen_if;
    import vga_timing_pkg::*;

    logic                 iEnable;
    logic [IdxW-1:0]      oHIndex;
    logic [IdxW-1:0]      oVIndex;
    logic                 oVgaHRequest;
    logic                 oVgaVRequest;
    logic                 oVgaRequest;
    logic [AddrW-1:0]     oPixelAddress;
    logic                 oHSync_n;
    logic                 oVSync_n;
    logic                 oLineStart;
    logic                 oFrameStart;
    logic [FrameCntW-1:0] oFrameCount;

    modport master (
        input  iEnable,
        output oHIndex, oVIndex, oVgaHRequest, oVgaVRequest, oVgaRequest, oPixelAddress,
        output oHSync_n, oVSync_n, oLineStart, oFrameStart, oFrameCount
    );

    modport slave (
        output iEnable,
        input  oHIndex, oVIndex, oVgaHRequest, oVgaVRequest, oVgaRequest, oPixelAddress,
        input  oHSync_n, oVSync_n, oLineStart, oFrameStart, oFrameCount
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-Total counter with enable; reset presets it to the last count so the first enabled
// step wraps to zero. Exposes next-state and wrap so the caller can decode ahead of the flop.
module vga_axis_counter #(
    parameter int unsigned Width = 10,
    parameter int unsigned Total = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic [Width-1:0] count_next,
    output logic             wrap
);

    localparam logic [Width-1:0] Last = Width'(Total - 1);

    logic [Width-1:0] count_q;

    always_comb begin
        wrap       = en && (count_q == Last);
        count_next = count_q;
        if (en) begin
            count_next = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= Last;
        end else begin
            count_q <= count_next;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_request_gen.sv
// VGA timing and pixel-request generator: two axis counters plus registered decode of requests,
// syncs, line/frame pulses, linear pixel address and frame count from the counters' next state.
module vga_request_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActiveDef,
    parameter int unsigned H_FP     = HFpDef,
    parameter int unsigned H_SYNC   = HSyncDef,
    parameter int unsigned H_BP     = HBpDef,
    parameter int unsigned V_ACTIVE = VActiveDef,
    parameter int unsigned V_FP     = VFpDef,
    parameter int unsigned V_SYNC   = VSyncDef,
    parameter int unsigned V_BP     = VBpDef
) (
    input logic               iVgaClk,
    input logic               reset,
    vga_request_gen_if.master vga
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [IdxW-1:0] HActiveIdx = IdxW'(H_ACTIVE);
    localparam logic [IdxW-1:0] VActiveIdx = IdxW'(V_ACTIVE);
    localparam logic [IdxW-1:0] HSyncFirst = IdxW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [IdxW-1:0] HSyncLast  = IdxW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [IdxW-1:0] VSyncFirst = IdxW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [IdxW-1:0] VSyncLast  = IdxW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [IdxW-1:0] h_idx, h_next;
    logic [IdxW-1:0] v_idx, v_next;
    logic            h_wrap, v_wrap, v_en;
    axis_decode_t    h_dec, v_dec;

    logic                 h_req_q, v_req_q, req_q;
    logic                 hsync_n_q, vsync_n_q;
    logic                 line_start_q, frame_start_q;
    logic [AddrW-1:0]     addr_q;
    logic [FrameCntW-1:0] frame_cnt_q;

    assign v_en = vga.iEnable & h_wrap;

    vga_axis_counter #(
        .Width (IdxW),
        .Total (HTotal)
    ) u_h_counter (
        .clk        (iVgaClk),
        .reset      (reset),
        .en         (vga.iEnable),
        .count      (h_idx),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .Width (IdxW),
        .Total (VTotal)
    ) u_v_counter (
        .clk        (iVgaClk),
        .reset      (reset),
        .en         (v_en),
        .count      (v_idx),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    always_comb begin
        h_dec = axis_decode(h_next, HActiveIdx, HSyncFirst, HSyncLast);
        v_dec = axis_decode(v_next, VActiveIdx, VSyncFirst, VSyncLast);
    end

    // v_wrap only fires together with h_wrap, so it alone marks entry to (0,0).
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            h_req_q       <= 1'b0;
            v_req_q       <= 1'b0;
            req_q         <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            addr_q        <= '0;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (vga.iEnable) begin
                h_req_q   <= h_dec.active;
                v_req_q   <= v_dec.active;
                req_q     <= h_dec.active & v_dec.active;
                hsync_n_q <= h_dec.sync_n;
                vsync_n_q <= v_dec.sync_n;
                if (v_wrap) begin
                    addr_q      <= '0;
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end else if (h_dec.active && v_dec.active) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign vga.oHIndex       = h_idx;
    assign vga.oVIndex       = v_idx;
    assign vga.oVgaHRequest  = h_req_q;
    assign vga.oVgaVRequest  = v_req_q;
    assign vga.oVgaRequest   = req_q;
    assign vga.oPixelAddress = addr_q;
    assign vga.oHSync_n      = hsync_n_q;
    assign vga.oVSync_n      = vsync_n_q;
    assign vga.oLineStart    = line_start_q;
    assign vga.oFrameStart   = frame_start_q;
    assign vga.oFrameCount   = frame_cnt_q;

endmodule

// File: tb/tb_vga_request_gen.sv
// Bench for vga_request_gen: a reduced-geometry instance (index 0) and a default 640x480
// instance (index 1), both checked every cycle against a position-based model plus literals.
module tb_vga_request_gen;

    localparam int S = 0;
    localparam int D = 1;

    localparam int GHA [2] = '{8, 640};
    localparam int GHF [2] = '{2, 16};
    localparam int GHS [2] = '{3, 96};
    localparam int GHB [2] = '{2, 48};
    localparam int GVA [2] = '{6, 480};
    localparam int GVF [2] = '{1, 10};
    localparam int GVS [2] = '{2, 2};
    localparam int GVB [2] = '{1, 33};

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hreq;
        logic        vreq;
        logic        req;
        logic [19:0] addr;
        logic        hs_n;
        logic        vs_n;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    logic clk;
    logic reset;
    logic enable;

    int vectors     = 0;
    int miscompares = 0;

    vga_request_gen_if bus_s ();
    vga_request_gen_if bus_d ();

    assign bus_s.iEnable = enable;
    assign bus_d.iEnable = enable;

    vga_request_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) u_dut_s (
        .iVgaClk (clk),
        .reset   (reset),
        .vga     (bus_s)
    );

    vga_request_gen u_dut_d (
        .iVgaClk (clk),
        .reset   (reset),
        .vga     (bus_d)
    );

    obs_t obs [2];

    always_comb begin
        obs[S].h    = bus_s.oHIndex;
        obs[S].v    = bus_s.oVIndex;
        obs[S].hreq = bus_s.oVgaHRequest;
        obs[S].vreq = bus_s.oVgaVRequest;
        obs[S].req  = bus_s.oVgaRequest;
        obs[S].addr = bus_s.oPixelAddress;
        obs[S].hs_n = bus_s.oHSync_n;
        obs[S].vs_n = bus_s.oVSync_n;
        obs[S].ls   = bus_s.oLineStart;
        obs[S].fs   = bus_s.oFrameStart;
        obs[S].fc   = bus_s.oFrameCount;
        obs[D].h    = bus_d.oHIndex;
        obs[D].v    = bus_d.oVIndex;
        obs[D].hreq = bus_d.oVgaHRequest;
        obs[D].vreq = bus_d.oVgaVRequest;
        obs[D].req  = bus_d.oVgaRequest;
        obs[D].addr = bus_d.oPixelAddress;
        obs[D].hs_n = bus_d.oHSync_n;
        obs[D].vs_n = bus_d.oVSync_n;
        obs[D].ls   = bus_d.oLineStart;
        obs[D].fs   = bus_d.oFrameStart;
        obs[D].fc   = bus_d.oFrameCount;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: beam position, whether a frame has begun since reset, pulses, frame count.
    int mh [2];
    int mv [2];
    int mfc [2];
    bit mstart [2];
    bit mls [2];
    bit mfs [2];
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int ht = GHA[i] + GHF[i] + GHS[i] + GHB[i];
            automatic int vt = GVA[i] + GVF[i] + GVS[i] + GVB[i];
            automatic int nh = mh[i] + 1;
            automatic int nv = mv[i];
            if (reset) begin
                mh[i]     <= ht - 1;
                mv[i]     <= vt - 1;
                mfc[i]    <= 0;
                mstart[i] <= 1'b0;
                mls[i]    <= 1'b0;
                mfs[i]    <= 1'b0;
            end else if (enable) begin
                if (nh == ht) begin
                    nh = 0;
                    nv = (nv + 1 == vt) ? 0 : nv + 1;
                end
                mh[i]  <= nh;
                mv[i]  <= nv;
                mls[i] <= (nh == 0);
                mfs[i] <= (nh == 0 && nv == 0);
                if (nh == 0 && nv == 0) begin
                    mstart[i] <= 1'b1;
                    mfc[i]    <= (mfc[i] + 1) % 256;
                end
            end else begin
                mls[i] <= 1'b0;
                mfs[i] <= 1'b0;
            end
        end
        if (reset) model_valid <= 1'b1;
    end

    function automatic obs_t model_out(input int i);
        obs_t o;
        int ha  = GHA[i];
        int va  = GVA[i];
        int hs0 = GHA[i] + GHF[i];
        int vs0 = GVA[i] + GVF[i];
        int a;
        o.h    = 10'(mh[i]);
        o.v    = 10'(mv[i]);
        o.hreq = (mh[i] < ha);
        o.vreq = (mv[i] < va);
        o.req  = o.hreq && o.vreq;
        o.hs_n = !(mh[i] >= hs0 && mh[i] < hs0 + GHS[i]);
        o.vs_n = !(mv[i] >= vs0 && mv[i] < vs0 + GVS[i]);
        if (!mstart[i]) a = 0;
        else if (mv[i] < va) a = mv[i] * ha + ((mh[i] < ha) ? mh[i] : ha - 1);
        else a = ha * va - 1;
        o.addr = 20'(a);
        o.ls   = mls[i];
        o.fs   = mfs[i];
        o.fc   = 8'(mfc[i]);
        return o;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                automatic obs_t e = model_out(i);
                vectors++;
                if (obs[i] !== e) begin
                    miscompares++;
                    $display({"FAIL model_%0d t=%0t: got h=%0d v=%0d hr=%b vr=%b r=%b a=%0d ",
                              "hs=%b vs=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hr=%b vr=%b ",
                              "r=%b a=%0d hs=%b vs=%b ls=%b fs=%b fc=%0d"},
                             i, $time, obs[i].h, obs[i].v, obs[i].hreq, obs[i].vreq,
                             obs[i].req, obs[i].addr, obs[i].hs_n, obs[i].vs_n, obs[i].ls,
                             obs[i].fs, obs[i].fc, e.h, e.v, e.hreq, e.vreq, e.req, e.addr,
                             e.hs_n, e.vs_n, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_to(input int h, input int v, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (mh[S] == h && mv[S] == v) found = 1'b1;
            else step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s: position (%0d,%0d) not reached, got (%0d,%0d)",
                     name, h, v, mh[S], mv[S]);
        end
    endtask

    initial begin
        int hs_low, hs_first, fs_cnt, last_fs, last_ls, hs_tot, vs_tot;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) step();

        // Reset values, with enable held high to show reset wins.
        chk("d_rst_h", obs[D].h, 799);
        chk("d_rst_v", obs[D].v, 524);
        chk("d_rst_req", obs[D].req, 0);
        chk("d_rst_hs", obs[D].hs_n, 1);
        chk("d_rst_vs", obs[D].vs_n, 1);
        chk("d_rst_addr", obs[D].addr, 0);
        chk("d_rst_fc", obs[D].fc, 0);
        chk("s_rst_h", obs[S].h, 14);
        chk("s_rst_v", obs[S].v, 9);

        reset = 1'b0;
        step();
        chk("d_first_h", obs[D].h, 0);
        chk("d_first_v", obs[D].v, 0);
        chk("d_first_fs", obs[D].fs, 1);
        chk("d_first_ls", obs[D].ls, 1);
        chk("d_first_req", obs[D].req, 1);
        chk("d_first_addr", obs[D].addr, 0);
        chk("d_first_fc", obs[D].fc, 1);

        // One full default line.
        hs_low   = 0;
        hs_first = -1;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (!obs[D].hs_n) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (i == 639) chk("d_addr_639", obs[D].addr, 639);
            if (i == 640) chk("d_hreq_640", obs[D].hreq, 0);
        end
        chk("d_hs_low_count", hs_low, 96);
        chk("d_hs_first", hs_first, 656);
        chk("d_line1_h", obs[D].h, 0);
        chk("d_line1_v", obs[D].v, 1);
        chk("d_line1_ls", obs[D].ls, 1);
        chk("d_line1_addr", obs[D].addr, 640);

        // Last active pixel and blanking hold on the reduced geometry.
        run_to(7, 5, "reach_last_active");
        chk("model_last_addr", int'(model_out(S).addr), 47);
        chk("s_last_addr", obs[S].addr, 47);
        chk("s_last_req", obs[S].req, 1);
        step();
        chk("s_blank_h", obs[S].h, 8);
        chk("s_blank_req", obs[S].req, 0);
        chk("s_blank_addr", obs[S].addr, 47);
        run_to(0, 0, "reach_frame_start");
        chk("s_new_addr", obs[S].addr, 0);
        chk("s_new_fs", obs[S].fs, 1);
        chk("s_new_ls", obs[S].ls, 1);

        // Pulse spacing and sync widths over three reduced frames.
        fs_cnt  = 0;
        last_fs = 0;
        last_ls = 0;
        hs_tot  = 0;
        vs_tot  = 0;
        for (int c = 1; c <= 450; c++) begin
            step();
            if (!obs[S].hs_n) hs_tot++;
            if (!obs[S].vs_n) vs_tot++;
            if (obs[S].ls) begin
                chk("s_ls_gap", c - last_ls, 15);
                last_ls = c;
            end
            if (obs[S].fs) begin
                chk("s_fs_gap", c - last_fs, 150);
                last_fs = c;
                fs_cnt++;
            end
        end
        chk("s_fs_count", fs_cnt, 3);
        chk("s_hs_low_total", hs_tot, 90);
        chk("s_vs_low_total", vs_tot, 90);

        // Freeze on a line start.
        run_to(0, 2, "reach_freeze");
        chk("s_freeze_ls_before", obs[S].ls, 1);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s_freeze_h", obs[S].h, 0);
            chk("s_freeze_v", obs[S].v, 2);
            chk("s_freeze_addr", obs[S].addr, 16);
            chk("s_freeze_ls", obs[S].ls, 0);
            chk("s_freeze_fs", obs[S].fs, 0);
        end
        enable = 1'b1;
        step();
        chk("s_resume_h", obs[S].h, 1);
        chk("s_resume_v", obs[S].v, 2);
        chk("s_resume_addr", obs[S].addr, 17);
        chk("s_resume_ls", obs[S].ls, 0);

        // Mid-frame reset.
        run_to(4, 4, "reach_midframe");
        chk("s_mid_addr", obs[S].addr, 36);
        reset = 1'b1;
        step();
        chk("s_mrst_h", obs[S].h, 14);
        chk("s_mrst_v", obs[S].v, 9);
        chk("s_mrst_addr", obs[S].addr, 0);
        chk("s_mrst_fc", obs[S].fc, 0);
        chk("s_mrst_req", obs[S].req, 0);
        chk("s_mrst_pulses", obs[S].ls + obs[S].fs, 0);
        chk("s_mrst_hs", obs[S].hs_n, 1);
        chk("d_mrst_h", obs[D].h, 799);
        chk("d_mrst_v", obs[D].v, 524);
        reset = 1'b0;
        step();
        chk("s_restart_fs", obs[S].fs, 1);
        chk("s_restart_fc", obs[S].fc, 1);
        chk("s_restart_addr", obs[S].addr, 0);
        chk("d_restart_fs", obs[D].fs, 1);
        chk("d_restart_fc", obs[D].fc, 1);

        // Frame counter wrap: 254 more frames reach 255, one more wraps to 0.
        repeat (254 * 150) step();
        chk("s_fc_255", obs[S].fc, 255);
        chk("s_fc_255_fs", obs[S].fs, 1);
        repeat (150) step();
        chk("s_fc_wrap", obs[S].fc, 0);
        chk("s_fc_wrap_fs", obs[S].fs, 1);
        chk("d_fc_hold", obs[D].fc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
